// File: rtl/counter_pkg.sv
// Shared mode encodings and the load-value clamp used by mod_counter.
// Pure declarations; no logic of its own.
package counter_pkg;

    localparam int MODE_WRAP    = 0;
    localparam int MODE_SAT     = 1;
    localparam int MODE_ONESHOT = 2;

    localparam int WIDTH_MAX    = 16;

    // Out-of-range load values collapse onto the top of the count range.
    function automatic int clamp_mod(input int value, input int modulus);
        return (value >= modulus) ? (modulus - 1) : value;
    endfunction

endpackage

// File: rtl/mod_counter_next.sv
// Combinational next-count step for mod_counter: +1/-1 with wrap or hold at the
// terminal value. Zero latency; carries no state and no flow control.
module mod_counter_next
    import counter_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 8,
    parameter int MODE    = MODE_WRAP
) (
    input  logic [WIDTH-1:0] num,
    input  logic             up,
    output logic [WIDTH-1:0] nxt,
    output logic             wrap,
    output logic             term
);

    // One spare bit so MODULUS = 2**WIDTH never overflows the compare or step.
    localparam logic [WIDTH:0] LAST = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] ONE  = (WIDTH+1)'(1);

    logic [WIDTH:0] num_x;
    logic [WIDTH:0] nxt_x;

    assign num_x = {1'b0, num};

    always_comb begin
        term  = up ? (num_x == LAST) : (num_x == '0);
        wrap  = 1'b0;
        nxt_x = num_x;
        if (term) begin
            if (MODE == MODE_WRAP) begin
                wrap  = 1'b1;
                nxt_x = up ? '0 : LAST;
            end
        end else begin
            nxt_x = up ? (num_x + ONE) : (num_x - ONE);
        end
    end

    assign nxt = WIDTH'(nxt_x);

endmodule

// File: rtl/mod_counter.sv
// Modulo-N up/down counter with load, terminal count, carry pulse and one-shot.
// One-edge latency for load/count; EN is active-low and simply holds the count.
module mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 8,
    parameter int MODE    = MODE_WRAP
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             EN,
    input  logic             UP,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] DIN,
    output logic [WIDTH-1:0] num,
    output logic             TC,
    output logic             CO,
    output logic             DONE
);

    if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
        $fatal(1, "mod_counter: WIDTH=%0d outside 1..%0d", WIDTH, WIDTH_MAX);
    end
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $fatal(1, "mod_counter: MODULUS=%0d outside 2..2**WIDTH", MODULUS);
    end
    if (MODE != MODE_WRAP && MODE != MODE_SAT && MODE != MODE_ONESHOT) begin : g_bad_mode
        $fatal(1, "mod_counter: MODE=%0d is not a known run mode", MODE);
    end

    logic [WIDTH-1:0] num_q, num_d;
    logic             co_q, co_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] step_nxt;
    logic             step_wrap;
    logic             step_term;

    mod_counter_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS),
        .MODE    (MODE)
    ) u_next (
        .num  (num_q),
        .up   (UP),
        .nxt  (step_nxt),
        .wrap (step_wrap),
        .term (step_term)
    );

    always_comb begin
        num_d  = num_q;
        co_d   = 1'b0;
        done_d = done_q;
        if (LOAD) begin
            num_d  = WIDTH'(clamp_mod(int'(DIN), MODULUS));
            done_d = 1'b0;
        end else if (MODE == MODE_ONESHOT && done_q) begin
            // A finished one-shot is parked until LOAD or CLR.
            num_d = num_q;
        end else if (!EN) begin
            num_d = step_nxt;
            if (MODE == MODE_WRAP) begin
                co_d = step_wrap;
            end
            if (MODE == MODE_ONESHOT && step_term) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            num_q  <= '0;
            co_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            num_q  <= num_d;
            co_q   <= co_d;
            done_q <= done_d;
        end
    end

    assign num  = num_q;
    assign CO   = co_q;
    assign DONE = done_q;
    assign TC   = ~EN & step_term;

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: four parameterisations driven in lock-step against a
// behavioural model, plus hand-computed literal expectations per scenario.
module tb_mod_counter;

    localparam int N = 4;
    localparam int MODS  [N] = '{8, 6, 8, 4};
    localparam int MODES [N] = '{0, 0, 1, 2};

    logic       CLK = 1'b0;
    logic       CLR;
    logic       EN;
    logic       UP;
    logic       LOAD;
    logic [2:0] DIN;

    logic [2:0] num_o  [N];
    logic       tc_o   [N];
    logic       co_o   [N];
    logic       done_o [N];

    int vectors    = 0;
    int miscompares = 0;

    int m_num  [N] = '{0, 0, 0, 0};
    bit m_co   [N] = '{0, 0, 0, 0};
    bit m_done [N] = '{0, 0, 0, 0};

    always #5 CLK = ~CLK;

    mod_counter #(.WIDTH(3), .MODULUS(8), .MODE(0)) u_w8 (
        .CLK(CLK), .CLR(CLR), .EN(EN), .UP(UP), .LOAD(LOAD), .DIN(DIN),
        .num(num_o[0]), .TC(tc_o[0]), .CO(co_o[0]), .DONE(done_o[0]));
    mod_counter #(.WIDTH(3), .MODULUS(6), .MODE(0)) u_w6 (
        .CLK(CLK), .CLR(CLR), .EN(EN), .UP(UP), .LOAD(LOAD), .DIN(DIN),
        .num(num_o[1]), .TC(tc_o[1]), .CO(co_o[1]), .DONE(done_o[1]));
    mod_counter #(.WIDTH(3), .MODULUS(8), .MODE(1)) u_s8 (
        .CLK(CLK), .CLR(CLR), .EN(EN), .UP(UP), .LOAD(LOAD), .DIN(DIN),
        .num(num_o[2]), .TC(tc_o[2]), .CO(co_o[2]), .DONE(done_o[2]));
    mod_counter #(.WIDTH(3), .MODULUS(4), .MODE(2)) u_o4 (
        .CLK(CLK), .CLR(CLR), .EN(EN), .UP(UP), .LOAD(LOAD), .DIN(DIN),
        .num(num_o[3]), .TC(tc_o[3]), .CO(co_o[3]), .DONE(done_o[3]));

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what each counter must hold after a rising edge, from the rules.
    task automatic model_step(input int i);
        int m;
        int last;
        bit at_end;
        m    = MODS[i];
        last = m - 1;
        at_end = UP ? (m_num[i] == last) : (m_num[i] == 0);
        if (LOAD) begin
            m_num[i]  = (int'(DIN) >= m) ? last : int'(DIN);
            m_co[i]   = 0;
            m_done[i] = 0;
        end else if (EN) begin
            m_co[i] = 0;
        end else begin
            m_co[i] = 0;
            case (MODES[i])
                0: begin
                    m_co[i]  = at_end;
                    m_num[i] = UP ? (m_num[i] + 1) % m : (m_num[i] + m - 1) % m;
                end
                1: begin
                    if (!at_end) m_num[i] = UP ? m_num[i] + 1 : m_num[i] - 1;
                end
                default: begin
                    if (!m_done[i]) begin
                        if (at_end) m_done[i] = 1;
                        else m_num[i] = UP ? m_num[i] + 1 : m_num[i] - 1;
                    end
                end
            endcase
        end
    endtask

    always @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            for (int i = 0; i < N; i++) begin
                m_num[i] = 0; m_co[i] = 0; m_done[i] = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) model_step(i);
        end
    end

    always @(negedge CLK) begin
        if (CLR === 1'b1) begin
            for (int i = 0; i < N; i++) begin
                int exp_tc;
                exp_tc = (!EN && (UP ? (m_num[i] == MODS[i] - 1) : (m_num[i] == 0))) ? 1 : 0;
                chk($sformatf("model num[%0d]", i),  int'(num_o[i]),  m_num[i]);
                chk($sformatf("model TC[%0d]", i),   int'(tc_o[i]),   exp_tc);
                chk($sformatf("model CO[%0d]", i),   int'(co_o[i]),   int'(m_co[i]));
                chk($sformatf("model DONE[%0d]", i), int'(done_o[i]), int'(m_done[i]));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    // Mid-cycle reset pulse, checked before any further edge.
    task automatic clr_pulse();
        CLR = 1'b0;
        #1;
        chk("clr num", int'(num_o[0]), 0);
        chk("clr CO", int'(co_o[1]), 0);
        chk("clr DONE", int'(done_o[3]), 0);
        #1;
        CLR = 1'b1;
    endtask

    initial begin
        int exp_up [7] = '{1, 2, 3, 4, 5, 0, 1};
        int exp_dn [6] = '{4, 3, 2, 1, 0, 5};

        CLR = 1'b0; EN = 1'b1; UP = 1'b1; LOAD = 1'b0; DIN = 3'd0;
        #3;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("reset num[%0d]", i), int'(num_o[i]), 0);
            chk($sformatf("reset CO[%0d]", i), int'(co_o[i]), 0);
            chk($sformatf("reset DONE[%0d]", i), int'(done_o[i]), 0);
        end
        CLR = 1'b1;
        tick();

        // Reset while holding 5
        LOAD = 1'b1; DIN = 3'd5; tick();
        chk("load5 w8", int'(num_o[0]), 5);
        LOAD = 1'b0;
        clr_pulse();

        // Wrap up, modulus 6
        EN = 1'b0; UP = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk($sformatf("wrap up num k=%0d", k), int'(num_o[1]), exp_up[k]);
            chk($sformatf("wrap up CO k=%0d", k), int'(co_o[1]), (k == 5) ? 1 : 0);
        end

        // Clamped load, then wrap down
        LOAD = 1'b1; DIN = 3'd7; tick();
        chk("clamp w6", int'(num_o[1]), 5);
        chk("load7 w8", int'(num_o[0]), 7);
        chk("clamp o4", int'(num_o[3]), 3);
        LOAD = 1'b0; UP = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("wrap dn num k=%0d", k), int'(num_o[1]), exp_dn[k]);
            chk($sformatf("wrap dn TC k=%0d", k), int'(tc_o[1]), (k == 4) ? 1 : 0);
        end
        chk("wrap dn borrow CO", int'(co_o[1]), 1);

        // Saturate
        LOAD = 1'b1; DIN = 3'd6; tick();
        chk("sat load", int'(num_o[2]), 6);
        LOAD = 1'b0; UP = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("sat num k=%0d", k), int'(num_o[2]), 7);
            chk($sformatf("sat CO k=%0d", k), int'(co_o[2]), 0);
        end
        UP = 1'b0; tick();
        chk("sat down", int'(num_o[2]), 6);

        // One-shot, modulus 4
        UP = 1'b1; EN = 1'b1;
        clr_pulse();
        EN = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("oneshot num %0d", k), int'(num_o[3]), k);
            chk($sformatf("oneshot DONE %0d", k), int'(done_o[3]), 0);
        end
        chk("oneshot TC", int'(tc_o[3]), 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("oneshot hold num k=%0d", k), int'(num_o[3]), 3);
            chk($sformatf("oneshot hold DONE k=%0d", k), int'(done_o[3]), 1);
        end
        LOAD = 1'b1; DIN = 3'd1; tick();
        chk("oneshot reload num", int'(num_o[3]), 1);
        chk("oneshot reload DONE", int'(done_o[3]), 0);
        LOAD = 1'b0; tick();
        chk("oneshot resume", int'(num_o[3]), 2);

        // LOAD beats count; EN=1 holds
        LOAD = 1'b1; EN = 1'b0; DIN = 3'd2; tick();
        chk("prio load w8", int'(num_o[0]), 2);
        LOAD = 1'b0; EN = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("hold w8 k=%0d", k), int'(num_o[0]), 2);
        end
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
